// File: rtl/ps2_kbd_cmd_sender.sv
// ----------------------------------------------------------------------------
// ps2_kbd_cmd_sender
//
// Host-to-keyboard command sequencer. Sends a one- or two-byte command
// (opcode, optional arg) through the PS2_Controller transmit handshake and
// waits for the keyboard reply after each byte: FA moves on, FE / transmit
// error / reply timeout retransmits the same byte up to MAX_RETRY times.
// Completion is reported with a one-cycle done pulse (plus error on failure).
//
// Ports
//   Clock, Resetn                  clock, asynchronous active-low reset
//   req, opcode, has_arg, arg      start request and command bytes (IDLE only)
//   busy, done, error              transaction status (all registered)
//   the_command, send_command      transmit request to PS2_Controller
//   command_was_sent               controller: byte shifted out
//   error_communication_timed_out  controller: transmit failed
//   received_data(_en)             controller receive byte / valid strobe
// ----------------------------------------------------------------------------
module ps2_kbd_cmd_sender #(
  parameter int ACK_TIMEOUT = 2500000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       req,
  input  logic [7:0] opcode,
  input  logic       has_arg,
  input  logic [7:0] arg,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  // A zero-width retry counter is not legal, so MAX_RETRY=0 keeps one bit.
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(MAX_RETRY);
  localparam logic [7:0]       KBD_ACK    = 8'hFA;
  localparam logic [7:0]       KBD_RESEND = 8'hFE;

  // ST_RETRY is the one-cycle retry decision between a failed attempt and
  // the retransmission, which guarantees a low cycle on send_command.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_NEXT     = 3'd3,
    ST_RETRY    = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAIL     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [7:0]       arg_q, arg_d;
  logic             has_arg_q, has_arg_d;
  logic             byte_sel_q, byte_sel_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             send_q, send_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       cur_byte;

  assign cur_byte     = byte_sel_q ? arg_q : opcode_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign send_command = send_q;
  assign the_command  = cmd_q;

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so that every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    arg_d      = arg_q;
    has_arg_d  = has_arg_q;
    byte_sel_d = byte_sel_q;
    tmo_cnt_d  = tmo_cnt_q;
    retry_d    = retry_q;
    cmd_d      = cmd_q;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    error_d    = 1'b0;
    send_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          opcode_d   = opcode;
          arg_d      = arg;
          has_arg_d  = has_arg;
          byte_sel_d = 1'b0;
          retry_d    = '0;
          tmo_cnt_d  = '0;
          cmd_d      = opcode;
          send_d     = 1'b1;
          state_d    = ST_SEND;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SEND: begin
        // A transmit error outranks a simultaneous command_was_sent.
        if (error_communication_timed_out) begin
          state_d = ST_RETRY;
        end else if (command_was_sent) begin
          tmo_cnt_d = '0;
          state_d   = ST_WAIT_ACK;
        end else begin
          send_d = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        // FA wins even in the terminal-count cycle; other bytes are ignored.
        if (received_data_en && (received_data == KBD_ACK)) begin
          state_d = ST_NEXT;
        end else if ((received_data_en && (received_data == KBD_RESEND)) ||
                     (tmo_cnt_q == TERM_CNT)) begin
          state_d = ST_RETRY;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      ST_RETRY: begin
        if (retry_q == RETRY_LIM) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = ST_FAIL;
        end else begin
          retry_d = retry_q + RTY_W'(1);
          cmd_d   = cur_byte;
          send_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_NEXT: begin
        if (!byte_sel_q && has_arg_q) begin
          byte_sel_d = 1'b1;
          retry_d    = '0;
          cmd_d      = arg_q;
          send_d     = 1'b1;
          state_d    = ST_SEND;
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_FAIL: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, context and output registers with asynchronous reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= ST_IDLE;
      opcode_q   <= 8'h00;
      arg_q      <= 8'h00;
      has_arg_q  <= 1'b0;
      byte_sel_q <= 1'b0;
      tmo_cnt_q  <= '0;
      retry_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      send_q     <= 1'b0;
      cmd_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      arg_q      <= arg_d;
      has_arg_q  <= has_arg_d;
      byte_sel_q <= byte_sel_d;
      tmo_cnt_q  <= tmo_cnt_d;
      retry_q    <= retry_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      send_q     <= send_d;
      cmd_q      <= cmd_d;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_cmd_sender.sv
// ----------------------------------------------------------------------------
// Testbench for ps2_kbd_cmd_sender. The bench plays the PS2_Controller and
// keyboard: each transmission is answered according to a per-attempt reply
// code. Expected transmitted bytes and the final error flag come from a
// table of hand-derived vectors, and for random vectors from a reference
// model that applies the retry rules byte by byte.
// ----------------------------------------------------------------------------
module tb_ps2_kbd_cmd_sender;

  localparam int T    = 200;
  localparam int MR   = 3;
  localparam int MAXS = 2 * (MR + 1);

  // Reply codes, one nibble per attempt (attempt 0 in the lowest nibble).
  localparam int R_ACK    = 0;  // FA after rep_dly
  localparam int R_RESEND = 1;  // FE after rep_dly
  localparam int R_NONE   = 2;  // silence until timeout
  localparam int R_TXERR  = 3;  // controller reports transmit error
  localparam int R_STRAY  = 4;  // AA, 6B, then FA
  localparam int R_TERM   = 5;  // FA exactly in the terminal-count cycle

  typedef struct packed {
    logic [7:0]  opc;
    logic        has_arg;
    logic [7:0]  arg;
    logic [31:0] reps;
    logic [7:0]  cws_dly;
    logic [7:0]  rep_dly;
    logic [3:0]  n_sends;
    logic [63:0] bytes;    // byte i of the send sequence at [8i+7:8i]
    logic        err;
  } vec_t;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b1;
  logic       req = 1'b0;
  logic [7:0] opcode = 8'h00;
  logic       has_arg = 1'b0;
  logic [7:0] arg = 8'h00;
  logic       busy, done, error, send_command;
  logic [7:0] the_command;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  vec_t tbl [11];

  ps2_kbd_cmd_sender #(.ACK_TIMEOUT(T), .MAX_RETRY(MR)) dut (
    .Clock                         (Clock),
    .Resetn                        (Resetn),
    .req                           (req),
    .opcode                        (opcode),
    .has_arg                       (has_arg),
    .arg                           (arg),
    .busy                          (busy),
    .done                          (done),
    .error                         (error),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .received_data                 (received_data),
    .received_data_en              (received_data_en)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    ncyc++;
  endtask

  // Advance to negedge 'target'; the DUT must not start a send or finish before it.
  task automatic wait_quiet(input int target);
    int bad;
    bad = 0;
    while (ncyc < target) begin
      tick();
      if (ncyc < target && (send_command || done)) bad++;
    end
    chk("quiet", 64'(bad), 64'd0);
  endtask

  task automatic pulse_rx(input int target, input logic [7:0] data);
    wait_quiet(target);
    received_data    = data;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
    received_data    = 8'h00;
  endtask

  function automatic vec_t mk(input logic [7:0] opc, input logic ha, input logic [7:0] a,
                              input logic [31:0] reps, input logic [3:0] n,
                              input logic [63:0] bytes, input logic err);
    vec_t r;
    r.opc = opc; r.has_arg = ha; r.arg = a; r.reps = reps;
    r.cws_dly = 8'd50; r.rep_dly = 8'd100;
    r.n_sends = n; r.bytes = bytes; r.err = err;
    return r;
  endfunction

  // Reference model: walk the bytes, consume one reply per transmission,
  // allow MR retries per byte, stop at the first exhausted byte.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int k, b, tries, code, nbytes;
    bit acked;
    r = v; r.n_sends = 4'd0; r.bytes = 64'd0; r.err = 1'b0;
    k = 0;
    nbytes = v.has_arg ? 2 : 1;
    for (b = 0; b < nbytes && !r.err; b++) begin
      tries = 0; acked = 1'b0;
      while (!acked && !r.err) begin
        r.bytes[8*r.n_sends +: 8] = (b == 0) ? v.opc : v.arg;
        r.n_sends = r.n_sends + 4'd1;
        code = int'(v.reps[4*k +: 4]);
        k++;
        if (code == R_ACK || code == R_STRAY || code == R_TERM) acked = 1'b1;
        else if (tries == MR) r.err = 1'b1;
        else tries++;
      end
    end
    return r;
  endfunction

  // Drive one transaction starting at a negedge with the DUT idle.
  task automatic run_txn(input vec_t v, input bit keep_req);
    int si, ai, n0, evt_at, bad, code, rd;
    opcode = v.opc; has_arg = v.has_arg; arg = v.arg; req = 1'b1;
    tick();
    chk("accept busy", 64'(busy), 64'd1);
    chk("accept send", 64'(send_command), 64'd1);
    if (!keep_req) begin
      req = 1'b0; opcode = ~v.opc; arg = ~v.arg; has_arg = ~v.has_arg;
    end
    rd = int'(v.rep_dly);
    si = 0; ai = 0;
    while (si < int'(v.n_sends)) begin
      chk("send byte", 64'(the_command), 64'(v.bytes[8*si +: 8]));
      si++;
      code = int'(v.reps[4*ai +: 4]);
      ai++;
      bad = 0;
      repeat (int'(v.cws_dly)) begin
        tick();
        if (!send_command || the_command !== v.bytes[8*(si-1) +: 8]) bad++;
      end
      chk("send hold", 64'(bad), 64'd0);
      n0 = ncyc;
      if (code == R_TXERR) begin
        error_communication_timed_out = 1'b1;
        tick();
        error_communication_timed_out = 1'b0;
        chk("txerr drop", 64'(send_command), 64'd0);
        evt_at = n0 + 2;
      end else begin
        command_was_sent = 1'b1;
        tick();
        command_was_sent = 1'b0;
        chk("sent drop", 64'(send_command), 64'd0);
        case (code)
          R_ACK:    begin pulse_rx(n0 + rd, 8'hFA); evt_at = n0 + rd + 2; end
          R_RESEND: begin pulse_rx(n0 + rd, 8'hFE); evt_at = n0 + rd + 2; end
          R_TERM:   begin pulse_rx(n0 + T, 8'hFA);  evt_at = n0 + T + 2;  end
          R_STRAY: begin
            req = 1'b1;
            pulse_rx(n0 + rd / 3, 8'hAA);
            if (!keep_req) req = 1'b0;
            pulse_rx(n0 + (2 * rd) / 3, 8'h6B);
            pulse_rx(n0 + rd, 8'hFA);
            evt_at = n0 + rd + 2;
          end
          default:  evt_at = n0 + T + 2;
        endcase
      end
      wait_quiet(evt_at);
      if (si < int'(v.n_sends)) begin
        chk("next send", 64'(send_command), 64'd1);
        chk("no early done", 64'(done), 64'd0);
      end else begin
        chk("done", 64'(done), 64'd1);
        chk("error", 64'(error), 64'(v.err));
        chk("busy at done", 64'(busy), 64'd1);
        chk("send at done", 64'(send_command), 64'd0);
      end
    end
    tick();
    chk("idle busy", 64'(busy), 64'd0);
    chk("done one cycle", 64'(done), 64'd0);
    chk("error one cycle", 64'(error), 64'd0);
    if (keep_req) begin
      tick();
      chk("b2b send", 64'(send_command), 64'd1);
      chk("b2b cmd", 64'(the_command), 64'(v.opc));
    end else begin
      wait_quiet(ncyc + 4);
      chk("stay idle", 64'(busy), 64'd0);
    end
  endtask

  initial begin : main
    vec_t v;
    int x, bad;
    tbl[0]  = mk(8'hFF, 1'b0, 8'h00, 32'h0,      4'd1, 64'hFF,           1'b0);
    tbl[1]  = mk(8'hED, 1'b1, 8'h07, 32'h00,     4'd2, 64'h07ED,         1'b0);
    tbl[2]  = mk(8'hF3, 1'b1, 8'h20, 32'h001,    4'd3, 64'h20F3F3,       1'b0);
    tbl[3]  = mk(8'hFF, 1'b0, 8'h00, 32'h2222,   4'd4, 64'hFFFFFFFF,     1'b1);
    tbl[4]  = mk(8'hED, 1'b1, 8'h02, 32'h04,     4'd2, 64'h02ED,         1'b0);
    tbl[5]  = mk(8'hF3, 1'b1, 8'h00, 32'h55,     4'd2, 64'h00F3,         1'b0);
    tbl[6]  = mk(8'hFF, 1'b0, 8'h00, 32'h03,     4'd2, 64'hFFFF,         1'b0);
    tbl[7]  = mk(8'hED, 1'b1, 8'h04, 32'h11110,  4'd5, 64'h04040404ED,   1'b1);
    tbl[8]  = mk(8'hF3, 1'b1, 8'h7F, 32'h030213, 4'd6, 64'h7F7FF3F3F3F3, 1'b0);
    tbl[9]  = mk(8'hFF, 1'b0, 8'h00, 32'h3333,   4'd4, 64'hFFFFFFFF,     1'b1);
    tbl[10] = mk(8'hED, 1'b1, 8'h99, 32'h1111,   4'd4, 64'hEDEDEDED,     1'b1);

    // Power-on reset: values must appear without a clock edge.
    #1 Resetn = 1'b0;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst send", 64'(send_command), 64'd0);
    chk("rst cmd", 64'(the_command), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst error", 64'(error), 64'd0);
    repeat (3) tick();
    Resetn = 1'b1;
    tick();
    chk("post rst busy", 64'(busy), 64'd0);
    chk("post rst send", 64'(send_command), 64'd0);

    for (int i = 0; i < 11; i++) run_txn(tbl[i], 1'b0);

    for (int n = 0; n < 20; n++) begin
      v = '0;
      v.opc     = 8'($urandom_range(0, 255));
      v.has_arg = 1'($urandom_range(0, 1));
      v.arg     = 8'($urandom_range(0, 255));
      for (int k = 0; k < MAXS; k++) begin
        x = int'($urandom_range(0, 9));
        v.reps[4*k +: 4] = (x < 5) ? 4'd0 : 4'(x - 4);
      end
      v.cws_dly = 8'($urandom_range(1, 30));
      v.rep_dly = 8'($urandom_range(3, 150));
      run_txn(model(v), 1'b0);
    end

    // Back-to-back acceptance, then reset in the middle of the new SEND.
    run_txn(tbl[0], 1'b1);
    #2 Resetn = 1'b0;
    #1;
    chk("mid-send rst send", 64'(send_command), 64'd0);
    chk("mid-send rst busy", 64'(busy), 64'd0);
    req = 1'b0;
    bad = 0;
    repeat (3) begin tick(); if (done || busy || send_command) bad++; end
    Resetn = 1'b1;
    repeat (3) begin tick(); if (done || busy || send_command) bad++; end
    chk("mid-send rst quiet", 64'(bad), 64'd0);
    run_txn(tbl[0], 1'b0);

    // Reset in the middle of WAIT_ACK.
    opcode = 8'hFF; has_arg = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (5) tick();
    command_was_sent = 1'b1;
    tick();
    command_was_sent = 1'b0;
    repeat (20) tick();
    chk("wait busy", 64'(busy), 64'd1);
    #2 Resetn = 1'b0;
    #1;
    chk("mid-wait rst busy", 64'(busy), 64'd0);
    chk("mid-wait rst send", 64'(send_command), 64'd0);
    bad = 0;
    repeat (3) begin tick(); if (done || busy || send_command) bad++; end
    Resetn = 1'b1;
    repeat (3) begin tick(); if (done || busy || send_command) bad++; end
    chk("mid-wait rst quiet", 64'(bad), 64'd0);
    run_txn(tbl[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
